vga_frame_scanner: RTL and testbench

Parametrised VGA scan-out engine that replaces the fixed-resolution VGA path inside the processor system.
- Generates VGA timing from CLOCK_50 through a pixel-clock divider.
- Fetches pixels from a framebuffer read port with optional pixel replication (SCALE).
- Drives the board VGA DAC pins with a fixed one-pixel pipeline latency.
- Colour depth, resolution and porch timing are parameters.

---
 rtl/vga_frame_scanner.sv | 195 +++++++++++++++++++
 tb/tb_vga_frame_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scanner.sv
// VGA scan-out engine: pixel-clock divider, h/v timing, framebuffer fetch with 2^SCALE_LOG2 replication.
// Pins lag the scan position by exactly one pixel period; no backpressure, fb_data must arrive 1 cycle after fb_rd.
module vga_frame_scanner #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int CLK_DIV    = 2,
   parameter int SCALE_LOG2 = 0,
   parameter int COLOR_BITS = 10,
   parameter int ADDR_W     = 19
) (
   input  logic                    CLOCK_50,
   input  logic                    reset_reset_n,
   input  logic                    enable,
   output logic [ADDR_W-1:0]       fb_addr,
   output logic                    fb_rd,
   input  logic [3*COLOR_BITS-1:0] fb_data,
   output logic [COLOR_BITS-1:0]   VGA_R,
   output logic [COLOR_BITS-1:0]   VGA_G,
   output logic [COLOR_BITS-1:0]   VGA_B,
   output logic                    VGA_HS,
   output logic                    VGA_VS,
   output logic                    VGA_BLANK_N,
   output logic                    VGA_SYNC_N,
   output logic                    VGA_CLK,
   output logic                    frame_start,
   output logic [7:0]              frame_count
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int PW      = 3 * COLOR_BITS;
   localparam int unsigned H_WORDS = H_ACTIVE >> SCALE_LOG2;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYN0 = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYN1 = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYN0 = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYN1 = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   logic [DW-1:0]     div_q, div_d;
   logic [HW-1:0]     h_q, h_d;
   logic [VW-1:0]     v_q, v_d;
   logic              vclk_q, vclk_d;
   logic              rd_q, rd_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              act0_q, act0_d, hs0_q, hs0_d, vs0_q, vs0_d;
   logic [PW-1:0]     hold_q, hold_d, pix_q, pix_d;
   logic              hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
   logic              fs_q, fs_d;
   logic [7:0]        fc_q, fc_d;

   logic              tick, active_c;
   logic [ADDR_W-1:0] addr_c;
   logic [PW-1:0]     pix_src;

   assign tick     = enable && (div_q == DIV_LAST);
   assign active_c = (h_q < H_ACT) && (v_q < V_ACT);
   assign addr_c   = ADDR_W'(32'(v_q >> SCALE_LOG2) * H_WORDS + 32'(h_q >> SCALE_LOG2));
   // With CLK_DIV = 2 the read data lands on the same edge as the stage-1 tick, so bypass the hold register.
   assign pix_src  = pend_q ? fb_data : hold_q;

   always_comb begin
      div_d     = div_q;
      h_d       = h_q;
      v_d       = v_q;
      vclk_d    = vclk_q;
      rd_d      = 1'b0;
      pend_d    = rd_q;
      addr_d    = addr_q;
      act0_d    = act0_q;
      hs0_d     = hs0_q;
      vs0_d     = vs0_q;
      hold_d    = hold_q;
      pix_d     = pix_q;
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
      fs_d      = 1'b0;
      fc_d      = fc_q;
      if (!enable) begin
         div_d     = '0;
         h_d       = '0;
         v_d       = '0;
         vclk_d    = 1'b0;
         pend_d    = 1'b0;
         addr_d    = '0;
         act0_d    = 1'b0;
         hs0_d     = 1'b1;
         vs0_d     = 1'b1;
         pix_d     = '0;
         hs_d      = 1'b1;
         vs_d      = 1'b1;
         blank_n_d = 1'b0;
         fc_d      = 8'd0;
      end else begin
         vclk_d = (div_q >= DIV_HALF);
         if (pend_q) hold_d = fb_data;
         if (tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
               h_d = '0;
               v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
               h_d = h_q + HW'(1);
            end
            act0_d    = active_c;
            hs0_d     = !((h_q >= H_SYN0) && (h_q < H_SYN1));
            vs0_d     = !((v_q >= V_SYN0) && (v_q < V_SYN1));
            rd_d      = active_c;
            addr_d    = addr_c;
            hs_d      = hs0_q;
            vs_d      = vs0_q;
            blank_n_d = act0_q;
            pix_d     = act0_q ? pix_src : '0;
            if ((h_q == '0) && (v_q == '0)) begin
               fs_d = 1'b1;
               fc_d = fc_q + 8'd1;
            end
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         div_q     <= '0;
         h_q       <= '0;
         v_q       <= '0;
         vclk_q    <= 1'b0;
         rd_q      <= 1'b0;
         pend_q    <= 1'b0;
         addr_q    <= '0;
         act0_q    <= 1'b0;
         hs0_q     <= 1'b1;
         vs0_q     <= 1'b1;
         hold_q    <= '0;
         pix_q     <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         fs_q      <= 1'b0;
         fc_q      <= 8'd0;
      end else begin
         div_q     <= div_d;
         h_q       <= h_d;
         v_q       <= v_d;
         vclk_q    <= vclk_d;
         rd_q      <= rd_d;
         pend_q    <= pend_d;
         addr_q    <= addr_d;
         act0_q    <= act0_d;
         hs0_q     <= hs0_d;
         vs0_q     <= vs0_d;
         hold_q    <= hold_d;
         pix_q     <= pix_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         blank_n_q <= blank_n_d;
         fs_q      <= fs_d;
         fc_q      <= fc_d;
      end
   end

   always @(posedge CLOCK_50) begin
      assert (CLK_DIV >= 2) else $error("vga_frame_scanner: CLK_DIV must be 2 or more");
   end

   assign fb_addr     = addr_q;
   assign fb_rd       = rd_q;
   assign VGA_R       = pix_q[PW-1:2*COLOR_BITS];
   assign VGA_G       = pix_q[2*COLOR_BITS-1:COLOR_BITS];
   assign VGA_B       = pix_q[COLOR_BITS-1:0];
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_CLK     = vclk_q;
   assign frame_start = fs_q;
   assign frame_count = fc_q;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: two small-timing instances (CLK_DIV 2 / SCALE 1x, CLK_DIV 3 / SCALE 2x)
// compared every cycle against a position-from-cycle-count model, plus literal timing expectations.
module tb_vga_frame_scanner;
   localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
   localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam int CB = 10, AW = 10;

   typedef struct packed {
      logic          rd;
      logic [AW-1:0] addr;
      logic          fs;
      logic [7:0]    fc;
      logic          hs, vs, bl, vclk;
      logic [CB-1:0] r, g, b;
   } exp_t;

   logic CLOCK_50 = 1'b0;
   logic rst_n = 1'b1;
   logic enable = 1'b0;
   logic [CB-1:0] key;

   logic [AW-1:0] a_addr, b_addr;
   logic a_rd, b_rd, a_hs, b_hs, a_vs, b_vs, a_bl, b_bl, a_sn, b_sn, a_vclk, b_vclk, a_fs, b_fs;
   logic [3*CB-1:0] a_data, b_data;
   logic [CB-1:0] a_r, a_g, a_b, b_r, b_g, b_b;
   logic [7:0] a_fc, b_fc;

   int m = 0;
   int n_chk = 0, n_pass = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   vga_frame_scanner #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VSW), .V_BP(VB), .CLK_DIV(2), .SCALE_LOG2(0), .COLOR_BITS(CB), .ADDR_W(AW)) dut_a (
      .CLOCK_50(CLOCK_50), .reset_reset_n(rst_n), .enable(enable), .fb_addr(a_addr), .fb_rd(a_rd),
      .fb_data(a_data), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs),
      .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sn), .VGA_CLK(a_vclk), .frame_start(a_fs), .frame_count(a_fc));

   vga_frame_scanner #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
      .V_SYNC(VSW), .V_BP(VB), .CLK_DIV(3), .SCALE_LOG2(1), .COLOR_BITS(CB), .ADDR_W(AW)) dut_b (
      .CLOCK_50(CLOCK_50), .reset_reset_n(rst_n), .enable(enable), .fb_addr(b_addr), .fb_rd(b_rd),
      .fb_data(b_data), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
      .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sn), .VGA_CLK(b_vclk), .frame_start(b_fs), .frame_count(b_fc));

   function automatic logic [3*CB-1:0] color(input logic [AW-1:0] a);
      return {a, a ^ key, CB'(a * 10'd7 + key)};
   endfunction

   // Framebuffers answer one cycle after the strobe and drive noise otherwise.
   always @(posedge CLOCK_50) begin
      a_data <= a_rd ? color(a_addr) : 30'($urandom);
      b_data <= b_rd ? color(b_addr) : 30'($urandom);
   end

   // m = number of consecutive enabled clock edges since the last reset or disable.
   always @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)      m <= 0;
      else if (enable) m <= m + 1;
      else             m <= 0;
   end

   function automatic logic pix_act(input int p);
      return ((p % HT) < HA) && (((p / HT) % VT) < VA);
   endfunction

   function automatic logic [AW-1:0] pix_addr(input int p, input int s);
      return AW'(((((p / HT) % VT) >> s) * (HA >> s)) + ((p % HT) >> s));
   endfunction

   // Scan position is pixel floor(m/d)-1 at stage 0 and one pixel earlier on the pins.
   function automatic exp_t model(input int mm, input int d, input int s);
      exp_t e;
      int t, p, q, hq, vq;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      t = mm / d;
      if (mm >= 1) e.vclk = ((mm - 1) % d) >= (d / 2);
      if (t >= 1) begin
         p = t - 1;
         e.addr = pix_addr(p, s);
         e.rd = (mm % d == 0) && pix_act(p);
         e.fs = (mm % d == 0) && (p % (HT * VT) == 0);
         e.fc = 8'(((t - 1) / (HT * VT) + 1) % 256);
      end
      if (t >= 2) begin
         q = t - 2;
         hq = q % HT;
         vq = (q / HT) % VT;
         e.hs = !((hq >= HA + HF) && (hq < HA + HF + HSW));
         e.vs = !((vq >= VA + VF) && (vq < VA + VF + VSW));
         e.bl = pix_act(q);
         if (e.bl) {e.r, e.g, e.b} = color(pix_addr(q, s));
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (t=%0t, m=%0d)", nm, act, req, $time, m);
   endtask

   task automatic check_dut(input string tag, input exp_t e, input logic rd, input logic [AW-1:0] addr,
                            input logic fs, input logic [7:0] fc, input logic hs, input logic vs,
                            input logic bl, input logic sn, input logic vclk,
                            input logic [CB-1:0] r, input logic [CB-1:0] g, input logic [CB-1:0] b);
      chk({tag, "_fb_rd"}, 32'(rd), 32'(e.rd));
      chk({tag, "_fb_addr"}, 32'(addr), 32'(e.addr));
      chk({tag, "_frame_start"}, 32'(fs), 32'(e.fs));
      chk({tag, "_frame_count"}, 32'(fc), 32'(e.fc));
      chk({tag, "_hs"}, 32'(hs), 32'(e.hs));
      chk({tag, "_vs"}, 32'(vs), 32'(e.vs));
      chk({tag, "_blank_n"}, 32'(bl), 32'(e.bl));
      chk({tag, "_sync_n"}, 32'(sn), 32'd0);
      chk({tag, "_vga_clk"}, 32'(vclk), 32'(e.vclk));
      chk({tag, "_rgb"}, 32'({r, g, b}), 32'({e.r, e.g, e.b}));
   endtask

   task automatic cyc();
      @(negedge CLOCK_50);
      check_dut("A", model(m, 2, 0), a_rd, a_addr, a_fs, a_fc, a_hs, a_vs, a_bl, a_sn, a_vclk, a_r, a_g, a_b);
      check_dut("B", model(m, 3, 1), b_rd, b_addr, b_fs, b_fc, b_hs, b_vs, b_bl, b_sn, b_vclk, b_r, b_g, b_b);
   endtask

   task automatic chk_reset_pins(input string nm);
      chk({nm, "_rgb"}, 32'({a_r, a_g, a_b}), 32'd0);
      chk({nm, "_blank_n"}, 32'(a_bl), 32'd0);
      chk({nm, "_hs"}, 32'(a_hs), 32'd1);
      chk({nm, "_vs"}, 32'(a_vs), 32'd1);
      chk({nm, "_fb_rd"}, 32'(a_rd), 32'd0);
   endtask

   logic hs_s[400], vs_s[400], bl_s[400], fs_s[400];
   logic [CB-1:0] r_s[400];
   int b_seq[24];
   int b_exp[24] = '{0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3, 4,4,5,5,6,6,7,7};

   initial begin
      int nb, px_at, i1, i2, cnt, guard, nfs;
      logic found;
      key = CB'($urandom);
      rst_n = 1'b0;
      repeat (3) cyc();
      chk_reset_pins("reset");
      chk("reset_addr", 32'(a_addr), 32'd0);
      chk("reset_fc", 32'(a_fc), 32'd0);
      chk("reset_vclk", 32'(a_vclk), 32'd0);
      rst_n = 1'b1;
      enable = 1'b1;

      nb = 0; px_at = -1;
      for (int i = 0; i < 400; i++) begin
         cyc();
         hs_s[i] = a_hs; vs_s[i] = a_vs; bl_s[i] = a_bl; fs_s[i] = a_fs; r_s[i] = a_r;
         if (a_rd && a_addr == AW'(19) && px_at < 0) px_at = i;
         if (b_rd && nb < 24) begin b_seq[nb] = int'(b_addr); nb++; end
      end
      chk("px32_seen", 32'(px_at >= 0 && px_at < 397), 32'd1);
      if (px_at >= 0 && px_at < 397) begin
         chk("px32_r_plus1", 32'(r_s[px_at + 1]), 32'd18);
         chk("px32_r_plus2", 32'(r_s[px_at + 2]), 32'd19);
         chk("px32_blank_n", 32'(bl_s[px_at + 2]), 32'd1);
      end
      i1 = -1; i2 = -1;
      for (int i = 0; i < 400; i++)
         if (fs_s[i]) begin if (i1 < 0) i1 = i; else if (i2 < 0) i2 = i; end
      chk("frame_period", 32'(i2 - i1), 32'd196);
      cnt = 0; for (int i = 100; i < 128; i++) cnt += int'(!hs_s[i]);
      chk("hs_low_per_line", 32'(cnt), 32'd4);
      cnt = 0; for (int i = 100; i < 296; i++) cnt += int'(!vs_s[i]);
      chk("vs_low_per_frame", 32'(cnt), 32'd28);
      cnt = 0; for (int i = 60; i < 88; i++) cnt += int'(bl_s[i]);
      chk("blank_high_per_line", 32'(cnt), 32'd16);
      chk("scale_reads", 32'(nb), 32'd24);
      for (int k = 0; k < 24; k++) chk($sformatf("scale_addr_%0d", k), 32'(b_seq[k]), 32'(b_exp[k]));

      // Abort a frame at h=5, v=2, then restart.
      enable = 1'b0; repeat (3) cyc(); enable = 1'b1;
      guard = 0;
      while (m != 66 && guard < 200) begin cyc(); guard++; end
      chk("pre_drop_blank_n", 32'(a_bl), 32'd1);
      enable = 1'b0;
      cyc();
      chk_reset_pins("drop");
      repeat (4) cyc();
      chk("drop_fb_rd_idle", 32'(a_rd), 32'd0);
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cyc();
         if (a_fs) begin found = 1'b1; chk("reenable_fc", 32'(a_fc), 32'd1); end
      end
      chk("reenable_fs_seen", 32'(found), 32'd1);

      // Asynchronous reset mid-line while a read is in flight.
      enable = 1'b0; cyc(); enable = 1'b1;
      repeat (61) cyc();
      @(posedge CLOCK_50); #1;
      chk("pre_reset_fb_rd", 32'(a_rd), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk_reset_pins("async_reset");
      chk("async_reset_fc", 32'(a_fc), 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (100) cyc();

      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(1, 150)) cyc();
         case ($urandom_range(0, 2))
            1: begin
               enable = 1'b0;
               repeat ($urandom_range(1, 20)) cyc();
               enable = 1'b1;
            end
            2: begin
               @(posedge CLOCK_50);
               #($urandom_range(1, 4)) rst_n = 1'b0;
               repeat ($urandom_range(1, 3)) cyc();
               rst_n = 1'b1;
            end
            default: ;
         endcase
      end

      // Run 256 frames to see frame_count wrap.
      enable = 1'b0; cyc(); enable = 1'b1;
      nfs = 0;
      for (int i = 0; i < 256 * 196 + 50 && nfs < 256; i++) begin
         cyc();
         if (a_fs) begin
            nfs++;
            if (nfs == 255) chk("fc_255", 32'(a_fc), 32'd255);
            if (nfs == 256) chk("fc_wrap", 32'(a_fc), 32'd0);
         end
      end
      chk("wrap_reached", 32'(nfs), 32'd256);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
